dcache_write_buffer: RTL and testbench
======================================

# dcache_write_buffer

Posted-write queue between the data cache's write port and the AXI bridge's `d_wr_*` port. It accepts cache write requests (line writebacks and uncached single-word stores) into a DEPTH-entry FIFO and retires them to the bridge in order. Once a write is queued, the cache is released immediately. The block drives the `write_buffer_empty` indication. It also flags reads that hit a queued line so the cache can hold them until the line has drained.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `ADDR_W`, 32: address width.

- `clock`  in  1  sole clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `wr_req`  in  1  cache write request.
- `wr_type`  in  3  `3'b100` = 4-word line; otherwise AXI size of a single beat.
- `wr_addr`  in  ADDR_W  write address.
- `wr_wstrb`  in  4  byte strobes.
- `wr_data`  in  128  line data; word 0 in `[31:0]`.
- `wr_rdy`  out  1  buffer can accept an entry this cycle.
- `out_wr_req`  out  1  head entry valid toward the bridge.
- `out_wr_type`  out  3  head type.
- `out_wr_addr`  out  ADDR_W  head address.
- `out_wr_wstrb`  out  4  head strobes.
- `out_wr_data`  out  128  head data.
- `out_wr_rdy`  in  1  bridge idle and accepting.
- `rd_chk_addr`  in  ADDR_W  address of the read the cache is about to issue.
- `rd_conflict`  out  1  read must stall.
- `write_buffer_empty`  out  1  no entries held.

## Operation
- Push: `wr_req && wr_rdy` in cycle N writes {type, addr, wstrb, data} at `wptr`. `wptr` and `count` update at edge N+1.
- Pop: `out_wr_req && out_wr_rdy` retires the head. `rptr` advances at the same edge.
- `out_wr_*` are driven straight from the entry at `rptr`.
- `out_wr_req = (count != 0)`.
- Ordering: strict FIFO with no merging or coalescing.
- `wr_rdy = (count != DEPTH)`. It depends only on registered state and never on `out_wr_rdy`.
- Push and pop in the same cycle: `count` is unchanged and both pointers advance.
- Full with a pop in the same cycle: the push is still refused because `wr_rdy` is 0.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. `count` is `$clog2(DEPTH)+1` bits.
- `write_buffer_empty = (count == 0)`.
- Reset, including mid-drain: pointers and count go to 0 and all entries are dropped.
  - Outputs after reset: `out_wr_req=0`, `wr_rdy=1`, `write_buffer_empty=1`, `rd_conflict=0`, `out_wr_*` data = 0.
  - Entry storage is not required to be cleared.

## Timing
- Write-to-bridge latency: an entry pushed at edge N is presented on `out_wr_req` from cycle N+1.
- No combinational path from `wr_*` to `out_wr_*`.
- The bridge samples the head in the cycle `out_wr_rdy` is high. The next entry (if any) is presented in the following cycle.
- `rd_conflict` is combinational from `rd_chk_addr` and the registered valid entries. The cache samples it in the same cycle it would assert its read request.
- An entry popped at edge N no longer contributes to `rd_conflict` in cycle N+1.

## Configuration
- Macro `DCACHE_WB_RAW_CHECK_EN`.
- Defined: `rd_conflict` = OR over valid entries of (`entry.addr[ADDR_W-1:4] == rd_chk_addr[ADDR_W-1:4]`). Comparison is line-granular for all entry types.
- Undefined: comparators are omitted and `rd_conflict = !write_buffer_empty`, a conservative full drain before any read.

## Structure
- Package `dcache_wb_pkg`:
  - `wb_entry_t` struct {type[2:0], addr, wstrb[3:0], data[127:0]}.
  - `WR_TYPE_LINE = 3'b100`.
  - `LINE_OFF_W = 4`.
- Sub-module `dcache_wb_fifo`: storage array plus pointers/count, exposing push/pop/head/full/empty and a per-entry valid vector.
- Top level: handshake mapping and the conflict comparators.

## Test plan
- Single line write: push addr `0x1C00_0040`, data `0x..4444_3333_2222_1111`, `out_wr_rdy=1`.
  - `out_wr_req` is high in cycle N+1 with identical fields.
  - Pop at edge N+2; `write_buffer_empty` returns to 1 in cycle N+2.
- Fill: DEPTH=4, `out_wr_rdy=0`, push 5 back-to-back.
  - `wr_rdy` drops after the 4th push; the 5th is held.
  - Raise `out_wr_rdy`: entries drain in order, then the 5th is accepted.
- Simultaneous push and pop at count=2: count stays 2 and the order is preserved across pointer wrap (push 6 total).
- RAW check: queue `0x0000_1230`.
  - `rd_chk_addr=0x0000_123C` gives conflict=1.
  - `0x0000_1240` gives conflict=0 (macro on) or 1 (macro off).
- Reset asserted mid-queue with 3 entries: all outputs immediately reach their reset values. There is no spurious `out_wr_req` after release.
- Uncached store: type `3'b010`, wstrb `4'b0011` pass through unchanged on `out_wr_*`.

Source files
------------

// File: rtl/dcache_wb_pkg.sv
// Shared types and constants for the data-cache posted-write buffer.
// Imported by dcache_wb_fifo and dcache_write_buffer.
package dcache_wb_pkg;

    localparam int          WB_ADDR_W    = 32;
    localparam logic [2:0]  WR_TYPE_LINE = 3'b100;
    localparam int          LINE_OFF_W   = 4;

    // Stored field order matches the cache request: type, address, strobes, line data.
    typedef struct packed {
        logic [2:0]           wtype;
        logic [WB_ADDR_W-1:0] addr;
        logic [3:0]           wstrb;
        logic [127:0]         data;
    } wb_entry_t;

    function automatic logic [WB_ADDR_W-LINE_OFF_W-1:0] lineOf(input logic [WB_ADDR_W-1:0] a);
        return a[WB_ADDR_W-1:LINE_OFF_W];
    endfunction

endpackage

// File: rtl/dcache_wb_fifo.sv
// Circular entry store for the write buffer: pointers, occupancy count and head view.
// With DCACHE_WB_RAW_CHECK_EN defined it also exports per-entry valid bits and line addresses.
module dcache_wb_fifo
    import dcache_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clock,
    input  logic      reset,
    input  logic      push_i,
    input  wb_entry_t push_entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
`ifdef DCACHE_WB_RAW_CHECK_EN
    ,
    output logic [DEPTH-1:0]                          valid_o,
    output logic [DEPTH-1:0][WB_ADDR_W-LINE_OFF_W-1:0] line_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             doPush, doPop;

    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (doPush) wptr_d = wptr_q + PTR_W'(1);
        if (doPop)  rptr_d = rptr_q + PTR_W'(1);
        if (doPush && !doPop)      count_d = count_q + (PTR_W+1)'(1);
        else if (!doPush && doPop) count_d = count_q - (PTR_W+1)'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left unreset; validity comes only from the pointers and count.
    always_ff @(posedge clock) begin
        if (doPush) mem_q[wptr_q] <= push_entry_i;
    end

`ifdef DCACHE_WB_RAW_CHECK_EN
    // A slot is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        valid_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_o[i] = ({1'b0, PTR_W'(i) - rptr_q} < count_q);
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : gLine
        assign line_o[g] = lineOf(mem_q[g].addr);
    end
`endif

endmodule

// File: rtl/dcache_write_buffer.sv
// Posted-write queue between the D-cache write port and the AXI bridge, plus read-after-write hazard flag.
// Define DCACHE_WB_RAW_CHECK_EN for line-granular conflict compare; otherwise any held entry stalls reads.
module dcache_write_buffer
    import dcache_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_req,
    input  logic [2:0]        wr_type,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_wstrb,
    input  logic [127:0]      wr_data,
    output logic              wr_rdy,
    output logic              out_wr_req,
    output logic [2:0]        out_wr_type,
    output logic [ADDR_W-1:0] out_wr_addr,
    output logic [3:0]        out_wr_wstrb,
    output logic [127:0]      out_wr_data,
    input  logic              out_wr_rdy,
    input  logic [ADDR_W-1:0] rd_chk_addr,
    output logic              rd_conflict,
    output logic              write_buffer_empty
);

    wb_entry_t pushEntry;
    wb_entry_t head;
    logic      full, empty;
    logic      push, pop;

    assign pushEntry = '{wtype: wr_type, addr: wr_addr, wstrb: wr_wstrb, data: wr_data};

    assign wr_rdy             = !full;
    assign push               = wr_req && wr_rdy;
    assign out_wr_req         = !empty;
    assign pop                = out_wr_req && out_wr_rdy;
    assign write_buffer_empty = empty;

    // Head fields are masked while empty so the unreset storage never leaks onto the bridge.
    assign out_wr_type  = empty ? '0 : head.wtype;
    assign out_wr_addr  = empty ? '0 : head.addr;
    assign out_wr_wstrb = empty ? '0 : head.wstrb;
    assign out_wr_data  = empty ? '0 : head.data;

`ifdef DCACHE_WB_RAW_CHECK_EN
    logic [DEPTH-1:0]                           entryValid;
    logic [DEPTH-1:0][WB_ADDR_W-LINE_OFF_W-1:0] entryLine;
    logic [DEPTH-1:0]                           lineHit;
    logic                                       unused_rdOffset;

    dcache_wb_fifo #(.DEPTH(DEPTH)) uFifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (pushEntry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty),
        .valid_o      (entryValid),
        .line_o       (entryLine)
    );

    // Line-granular match regardless of entry type; a single-word store blocks its whole line.
    always_comb begin
        lineHit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            lineHit[i] = entryValid[i] && (entryLine[i] == rd_chk_addr[ADDR_W-1:LINE_OFF_W]);
        end
    end

    assign rd_conflict     = |lineHit;
    assign unused_rdOffset = ^rd_chk_addr[LINE_OFF_W-1:0];
`else
    logic unused_rdAddr;

    dcache_wb_fifo #(.DEPTH(DEPTH)) uFifo (
        .clock        (clock),
        .reset        (reset),
        .push_i       (push),
        .push_entry_i (pushEntry),
        .pop_i        (pop),
        .head_o       (head),
        .full_o       (full),
        .empty_o      (empty)
    );

    assign rd_conflict   = !empty;
    assign unused_rdAddr = ^rd_chk_addr;
`endif

endmodule

// File: tb/tb_dcache_write_buffer.sv
// Self-checking bench for dcache_write_buffer: directed scenarios then random traffic against a queue model.
// Honours DCACHE_WB_RAW_CHECK_EN the same way as the design.
module tb_dcache_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              wr_req;
    logic [2:0]        wr_type;
    logic [ADDR_W-1:0] wr_addr;
    logic [3:0]        wr_wstrb;
    logic [127:0]      wr_data;
    logic              wr_rdy;
    logic              out_wr_req;
    logic [2:0]        out_wr_type;
    logic [ADDR_W-1:0] out_wr_addr;
    logic [3:0]        out_wr_wstrb;
    logic [127:0]      out_wr_data;
    logic              out_wr_rdy;
    logic [ADDR_W-1:0] rd_chk_addr;
    logic              rd_conflict;
    logic              write_buffer_empty;

    typedef struct {
        logic [2:0]   t;
        logic [31:0]  a;
        logic [3:0]   s;
        logic [127:0] d;
    } ent_t;

    ent_t q[$];
    int   total = 0;
    int   bad   = 0;

    localparam logic [127:0] LINE_DATA = 128'h8888_7777_6666_5555_4444_3333_2222_1111;

    always #5 clock = ~clock;

    dcache_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock              (clock),
        .reset              (reset),
        .wr_req             (wr_req),
        .wr_type            (wr_type),
        .wr_addr            (wr_addr),
        .wr_wstrb           (wr_wstrb),
        .wr_data            (wr_data),
        .wr_rdy             (wr_rdy),
        .out_wr_req         (out_wr_req),
        .out_wr_type        (out_wr_type),
        .out_wr_addr        (out_wr_addr),
        .out_wr_wstrb       (out_wr_wstrb),
        .out_wr_data        (out_wr_data),
        .out_wr_rdy         (out_wr_rdy),
        .rd_chk_addr        (rd_chk_addr),
        .rd_conflict        (rd_conflict),
        .write_buffer_empty (write_buffer_empty)
    );

    task automatic checkOutput(input string tag, input logic [191:0] got, input logic [191:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Any queued write to the same 16-byte line stalls the read; without the compare, any queued write does.
    function automatic logic modelConflict(input logic [31:0] ra);
`ifdef DCACHE_WB_RAW_CHECK_EN
        foreach (q[i]) if ((q[i].a >> 4) == (ra >> 4)) return 1'b1;
        return 1'b0;
`else
        return q.size() != 0;
`endif
    endfunction

    task automatic checkAll(input logic [31:0] rchk);
        logic [191:0] expHead;
        checkOutput("wr_rdy", wr_rdy, q.size() != DEPTH);
        checkOutput("out_wr_req", out_wr_req, q.size() != 0);
        checkOutput("wb_empty", write_buffer_empty, q.size() == 0);
        checkOutput("rd_conflict", rd_conflict, modelConflict(rchk));
        expHead = '0;
        if (q.size() != 0) expHead = {q[0].t, q[0].a, q[0].s, q[0].d};
        checkOutput("head", {out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data}, expHead);
    endtask

    // Entered just after a rising edge; drives one cycle, checks, and advances the model at the edge.
    task automatic applyStimulus(input logic req, input logic [2:0] t, input logic [31:0] a,
                                 input logic [3:0] s, input logic [127:0] d,
                                 input logic ordy, input logic [31:0] rchk);
        logic doPush, doPop;
        ent_t e;
        wr_req      = req;
        wr_type     = t;
        wr_addr     = a;
        wr_wstrb    = s;
        wr_data     = d;
        out_wr_rdy  = ordy;
        rd_chk_addr = rchk;
        #2;
        checkAll(rchk);
        doPop  = (q.size() != 0) && ordy;
        doPush = req && (q.size() != DEPTH);
        e = '{t: t, a: a, s: s, d: d};
        @(posedge clock);
        if (doPop)  void'(q.pop_front());
        if (doPush) q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic ordy, input logic [31:0] rchk);
        applyStimulus(1'b0, 3'b000, 32'h0, 4'h0, 128'h0, ordy, rchk);
    endtask

    task automatic doReset();
        wr_req     = 1'b0;
        out_wr_rdy = 1'b0;
        reset      = 1'b1;
        q.delete();
        #2;
        checkOutput("rst_wr_rdy", wr_rdy, 1'b1);
        checkOutput("rst_out_req", out_wr_req, 1'b0);
        checkOutput("rst_empty", write_buffer_empty, 1'b1);
        checkOutput("rst_conflict", rd_conflict, 1'b0);
        checkOutput("rst_head", {out_wr_type, out_wr_addr, out_wr_wstrb, out_wr_data}, 192'h0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        wr_req      = 1'b0;
        wr_type     = '0;
        wr_addr     = '0;
        wr_wstrb    = '0;
        wr_data     = '0;
        out_wr_rdy  = 1'b0;
        rd_chk_addr = '0;
        @(posedge clock);
        #1;
        doReset();

        // Single line write, drained immediately.
        applyStimulus(1'b1, 3'b100, 32'h1C00_0040, 4'hF, LINE_DATA, 1'b1, 32'h0);
        idle(1'b1, 32'h1C00_0048);
        idle(1'b1, 32'h1C00_0048);

        // Fill past capacity with the bridge stalled, then drain while the fifth waits.
        for (int k = 0; k < 5; k++)
            applyStimulus(1'b1, 3'b100, 32'h1C00_0100 + 32'(k * 16), 4'hF,
                          {4{32'(k + 1)}}, 1'b0, 32'h0);
        for (int k = 0; k < 2; k++)
            applyStimulus(1'b1, 3'b100, 32'h1C00_0140, 4'hF, {4{32'd5}}, 1'b1, 32'h0);
        for (int k = 0; k < 5; k++) idle(1'b1, 32'h0);

        // Steady push+pop at occupancy 2 across pointer wrap.
        for (int k = 0; k < 6; k++)
            applyStimulus(1'b1, 3'b100, 32'h1C00_0200 + 32'(k * 16), 4'hF,
                          {4{32'(k + 16)}}, k >= 2, 32'h0);
        for (int k = 0; k < 3; k++) idle(1'b1, 32'h0);

        // Read-after-write hazard on the same and the neighbouring line.
        applyStimulus(1'b1, 3'b100, 32'h0000_1230, 4'hF, LINE_DATA, 1'b0, 32'h0);
        idle(1'b0, 32'h0000_123C);
        idle(1'b0, 32'h0000_1240);
        idle(1'b1, 32'h0000_1240);
        idle(1'b1, 32'h0000_123C);

        // Reset in the middle of a queue of three.
        for (int k = 0; k < 3; k++)
            applyStimulus(1'b1, 3'b100, 32'h1C00_0300 + 32'(k * 16), 4'hF,
                          {4{32'(k + 32)}}, 1'b0, 32'h0);
        doReset();
        idle(1'b1, 32'h1C00_0300);
        idle(1'b1, 32'h1C00_0310);

        // Uncached partial store passes type and strobes through untouched.
        applyStimulus(1'b1, 3'b010, 32'h1FD0_0004, 4'b0011, 128'h0000_0000_0000_0000_0000_0000_CAFE_BEEF,
                      1'b0, 32'h0);
        idle(1'b1, 32'h1FD0_0000);
        idle(1'b1, 32'h0);

        // Random traffic over a few lines so hazards and full/empty edges recur.
        for (int n = 0; n < 1500; n++) begin
            logic [2:0]   t;
            logic [31:0]  a, r;
            logic [127:0] d;
            int           bias;
            bias = (n / 250) % 4;
            t = ($urandom % 2) ? 3'b100 : 3'($urandom_range(0, 2));
            a = 32'h1C00_0000 | (32'($urandom_range(0, 7)) << 4) | 32'($urandom % 16);
            r = 32'h1C00_0000 | (32'($urandom_range(0, 7)) << 4) | 32'($urandom % 16);
            d = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom % 3) != 0, t, a, 4'($urandom), d,
                          int'($urandom % 4) <= bias, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
